// File: rtl/spi_rx_deserializer_if.sv
// ---------------------------------------------------------------------------
// spi_rx_deserializer_if
//   Valid/ready word interface between the SPI receive deserializer and the
//   downstream consumer.
//   Signals:
//     rx_data  [DATA_W]  received word, stable while rx_valid=1
//     rx_valid           word available
//     rx_ready           consumer accepts word when rx_valid && rx_ready
//   Modports:
//     master  : word producer (the deserializer)
//     slave   : word consumer
// ---------------------------------------------------------------------------
interface spi_rx_deserializer_if #(
    parameter int DATA_W = 6
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/spi_rx_deserializer.sv
// ---------------------------------------------------------------------------
// spi_rx_deserializer
//   Receives 3-wire serial frames (sclk/cs_n/sdi), samples sdi on each sclk
//   rising edge while cs_n is low, assembles DATA_W-bit LSB-first words and
//   presents them on a valid/ready interface. Flags frames with the wrong
//   bit count, dropped words (overrun) and, optionally, parity errors.
//   Optional feature macro: SPI_RX_PARITY_EN (adds a trailing even-parity
//   bit per frame; mismatching words are not delivered).
//   Ports:
//     clk, rst_n   system clock, asynchronous active-low reset
//     sclk         serial clock (each level held >= 1 clk period)
//     cs_n         active-low chip select framing one word
//     sdi          serial data, LSB first
//     rx_if        valid/ready word output (master modport)
//     frame_err    1-cycle pulse: frame ended with wrong bit count
//     overrun      1-cycle pulse: completed word dropped, old word held
//     parity_err   1-cycle pulse: parity mismatch (0 without parity)
// ---------------------------------------------------------------------------
module spi_rx_deserializer #(
    parameter int DATA_W      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic                 sdi,
    spi_rx_deserializer_if.master rx_if,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

`ifdef SPI_RX_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int CNT_W = $clog2(NBITS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    // Identical synchroniser chains keep sdi aligned with its sclk edge.
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q,   cs_sync_d;
    logic [SYNC_STAGES-1:0] sdi_sync_q,  sdi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0]   shreg_q, shreg_d;
    logic [DATA_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;
`ifdef SPI_RX_PARITY_EN
    logic               parity_err_q, parity_err_d;
`endif

    logic sclk_s, cs_s, sdi_s, sclk_rise;
    logic word_done, word_ok;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0],   cs_n};
        sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0],  sdi};
        sclk_prev_d = sclk_s;

        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        word_done   = 1'b0;
        word_ok     = 1'b1;
`ifdef SPI_RX_PARITY_EN
        parity_err_d = 1'b0;
`endif

        if (rx_valid_q && rx_if.rx_ready) begin
            rx_valid_d = 1'b0;
        end

        // cs_n is tested before sclk_rise in every state: a deselect seen in
        // the same cycle as an edge ignores the edge.
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                shreg_d   = '0;
                if (!cs_s) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    frame_err_d = 1'b1;
                    bit_cnt_d   = '0;
                    shreg_d     = '0;
                    state_d     = IDLE;
                end else if (sclk_rise) begin
                    shreg_d[bit_cnt_q] = sdi_s;
                    bit_cnt_d          = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(NBITS - 1)) begin
                        word_done = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                if (cs_s) begin
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SPI_RX_PARITY_EN
        if (word_done && ((^shreg_d[DATA_W-1:0]) != shreg_d[NBITS-1])) begin
            word_ok      = 1'b0;
            parity_err_d = 1'b1;
        end
`endif

        // A word completing during a handshake replaces the old one with no
        // idle cycle; otherwise a held word is never overwritten.
        if (word_done && word_ok) begin
            if (!rx_valid_q || rx_if.rx_ready) begin
                rx_data_d  = shreg_d[DATA_W-1:0];
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            sdi_sync_q  <= '0;
            sclk_prev_q <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SPI_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            sdi_sync_q  <= sdi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef SPI_RX_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign rx_if.rx_data  = rx_data_q;
    assign rx_if.rx_valid = rx_valid_q;
    assign frame_err      = frame_err_q;
    assign overrun        = overrun_q;
`ifdef SPI_RX_PARITY_EN
    assign parity_err     = parity_err_q;
`else
    assign parity_err     = 1'b0;
`endif

endmodule
